mem_arbiter: RTL
================

# mem_arbiter

Two-port memory arbiter that shares the single 128-bit backing-memory interface between the instruction cache and the data cache. It sits between the two cache instances' `mem_*` ports and the memory model. It grants one cache at a time, forwards that cache's request and write-data channels, and routes the read response back to the owner. Exactly one transaction is outstanding at any time, and arbitration is round-robin.

## Interface
Parameters:
- `MEM_ADDR_BITS`, default 28: memory block address width (word address bits [29:2]).
- `MEM_DATA_BITS`, default 128: memory data width. The mask is `MEM_DATA_BITS/8` = 16 bits.

Ports. `<p>` is `ic` (instruction cache) or `dc` (data cache); each `<p>` group exists for both.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `<p>_mem_req_valid`  in  1  requester has a request.
- `<p>_mem_req_ready`  out  1  request accepted this cycle.
- `<p>_mem_req_addr`  in  MEM_ADDR_BITS  block address.
- `<p>_mem_req_rw`  in  1  1 = write, 0 = read.
- `<p>_mem_req_data_valid`  in  1  write data present.
- `<p>_mem_req_data_ready`  out  1  write data accepted this cycle.
- `<p>_mem_req_data_bits`  in  MEM_DATA_BITS  write data.
- `<p>_mem_req_data_mask`  in  MEM_DATA_BITS/8  byte mask.
- `<p>_mem_resp_valid`  out  1  read response for `<p>`.
- `<p>_mem_resp_data`  out  MEM_DATA_BITS  response data, broadcast to both requesters.
- `mem_req_valid`/`mem_req_ready`/`mem_req_addr`/`mem_req_rw`/`mem_req_data_valid`/`mem_req_data_ready`/`mem_req_data_bits`/`mem_req_data_mask`/`mem_resp_valid`/`mem_resp_data`: the memory side. These have the same widths as the `<p>` signals, with directions mirrored.
- `err_unexpected_resp`  out  1  sticky flag: `mem_resp_valid` was seen outside the RESP state.

## Operation
State registers:
- `state` ∈ {IDLE, REQ, RESP}.
- `owner` (0 = ic, 1 = dc).
- `last_owner`.
- `req_done` and `data_done` flags.
- `err_unexpected_resp`.

Reset (asynchronous) values: state = IDLE, owner = ic, last_owner = ic, flags = 0, err = 0. While reset is asserted, every output is 0.

IDLE:
- No forwarding. All `*_ready`, `*_resp_valid`, `mem_req_valid` and `mem_req_data_valid` are 0.
- If exactly one `<p>_mem_req_valid` is high: owner ← that requester, go to REQ.
- If both are high: owner ← the requester that is not `last_owner`. Because `last_owner` resets to ic, the first tie goes to dc.
- If neither is high: stay in IDLE.

REQ (forwarding, combinational):
- `mem_req_valid/addr/rw/data_valid/data_bits/data_mask` equal the owner's signals.
- Owner's `mem_req_ready` = `mem_req_ready & ~req_done`.
- Owner's `data_ready` = `mem_req_data_ready & rw & ~data_done`.
- The non-owner sees all readys 0.
- Forwarded `mem_req_valid` is gated by `~req_done`; forwarded `mem_req_data_valid` is gated by `~data_done`.
- Request fire = forwarded valid & `mem_req_ready`; this sets `req_done`. Data fire sets `data_done`. Both may fire in the same cycle, in either order.
- Read (rw = 0): on request fire, go to RESP; flags clear.
- Write: when `req_done` and `data_done` are both set (counting this cycle's fires), set `last_owner` ← owner, clear the flags, and go to IDLE. No response is expected for a write.
- If the owner drops `mem_req_valid` before the request fires: abandon, go to IDLE, and leave `last_owner` unchanged.

RESP:
- Owner's `resp_valid` = `mem_resp_valid`; the non-owner's is 0.
- `<p>_mem_resp_data` = `mem_resp_data` at all times.
- On `mem_resp_valid`: `last_owner` ← owner, go to IDLE.

Unexpected response: `mem_resp_valid` in IDLE or REQ is not forwarded, and sets `err_unexpected_resp` until reset.

## Timing
- Arbitration decision takes 1 cycle: a valid seen in IDLE is forwarded to memory in the next cycle.
- Request, data and response paths are combinational pass-through, with zero added latency once granted.
- Minimum read: IDLE → REQ (fire) → RESP (response in the same cycle) → IDLE. That is 3 cycles from the requester's valid to being able to accept the next grant.
- Minimum write: IDLE → REQ with both fires in one cycle → IDLE. That is 2 cycles.
- A requester that keeps `mem_req_valid` high across back-to-back transactions gets round-robin alternation whenever the other requester is also waiting.
- `reset` asserted mid-transaction: immediate return to IDLE, and all outputs drop to 0 asynchronously.

## Test plan
- Lone ic read of addr 0x0000010, memory ready, response 4 cycles later with data 0x…DEADBEEF → `ic_mem_req_ready` pulses once; `ic_mem_resp_valid` is high for exactly 1 cycle carrying 0x…DEADBEEF; `dc_mem_resp_valid` stays 0.
- ic and dc both raise valid in the same cycle after reset → dc is granted first and ic second. A third simultaneous pair is granted dc again, because `last_owner` = ic after the ic transaction.
- dc write of addr 0x00000AB with mask 0x00FF: `mem_req_ready` on cycle 1 and `mem_req_data_ready` delayed to cycle 3 → each fires exactly once, and the FSM returns to IDLE after cycle 3 without waiting for a response.
- `mem_resp_valid` pulsed while in IDLE → no `resp_valid` on either port; `err_unexpected_resp` = 1 and stays at 1.
- Assert `reset` during RESP of a dc read → all outputs go to 0 immediately; after release, state is IDLE and the next tie goes to dc.
- Owner drops `mem_req_valid` in REQ while `mem_req_ready` = 0 → the FSM returns to IDLE with no ready pulse, and the other pending requester is granted on the following arbitration.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one 128-bit backing-memory port between the instruction cache (ic)
// and the data cache (dc). One transaction is outstanding at a time; ties are
// broken round-robin against the requester that last completed a transaction.
//
// Ports
//   clk, reset                 clock and asynchronous active-high reset
//   <p>_mem_req_*   (p=ic,dc)  request + write-data channels from each cache
//   <p>_mem_resp_*             read response back to each cache (data broadcast)
//   mem_req_* / mem_resp_*     memory-side mirror of the cache channels
//   err_unexpected_resp        sticky: a memory response arrived outside RESP
//
// Once a requester is granted, the request, write-data and response paths
// are combinational pass-throughs; only the grant decision costs a cycle.

module mem_arbiter #(
  parameter int MEM_ADDR_BITS = 28,
  parameter int MEM_DATA_BITS = 128
) (
  input  logic                       clk,
  input  logic                       reset,

  // instruction cache side
  input  logic                       ic_mem_req_valid,
  output logic                       ic_mem_req_ready,
  input  logic [MEM_ADDR_BITS-1:0]   ic_mem_req_addr,
  input  logic                       ic_mem_req_rw,
  input  logic                       ic_mem_req_data_valid,
  output logic                       ic_mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   ic_mem_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] ic_mem_req_data_mask,
  output logic                       ic_mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   ic_mem_resp_data,

  // data cache side
  input  logic                       dc_mem_req_valid,
  output logic                       dc_mem_req_ready,
  input  logic [MEM_ADDR_BITS-1:0]   dc_mem_req_addr,
  input  logic                       dc_mem_req_rw,
  input  logic                       dc_mem_req_data_valid,
  output logic                       dc_mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   dc_mem_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] dc_mem_req_data_mask,
  output logic                       dc_mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   dc_mem_resp_data,

  // memory side
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  output logic                       mem_req_rw,
  output logic                       mem_req_data_valid,
  input  logic                       mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                       mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,

  output logic                       err_unexpected_resp
);

  localparam int MASK_BITS = MEM_DATA_BITS / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // owner encoding: 0 = ic, 1 = dc
  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_owner_q, last_owner_d;
  logic   req_done_q, req_done_d;
  logic   data_done_q, data_done_d;
  logic   err_q, err_d;

  // Owner-selected view of the cache request channels
  logic                     own_valid;
  logic [MEM_ADDR_BITS-1:0] own_addr;
  logic                     own_rw;
  logic                     own_dvalid;
  logic [MEM_DATA_BITS-1:0] own_dbits;
  logic [MASK_BITS-1:0]     own_dmask;

  assign own_valid  = owner_q ? dc_mem_req_valid      : ic_mem_req_valid;
  assign own_addr   = owner_q ? dc_mem_req_addr       : ic_mem_req_addr;
  assign own_rw     = owner_q ? dc_mem_req_rw         : ic_mem_req_rw;
  assign own_dvalid = owner_q ? dc_mem_req_data_valid : ic_mem_req_data_valid;
  assign own_dbits  = owner_q ? dc_mem_req_data_bits  : ic_mem_req_data_bits;
  assign own_dmask  = owner_q ? dc_mem_req_data_mask  : ic_mem_req_data_mask;

  // Reset is folded in so outputs drop in the same instant reset rises,
  // independent of when the state register itself settles.
  logic in_req, in_resp;
  assign in_req  = (state_q == REQ)  & ~reset;
  assign in_resp = (state_q == RESP) & ~reset;

  // Handshake terms. The done flags mask each channel once it has fired so a
  // write whose address and data complete in different cycles never repeats.
  logic fwd_valid, fwd_dvalid, grant_ready, grant_dready;
  logic req_fire, data_fire;

  assign fwd_valid    = in_req & own_valid  & ~req_done_q;
  assign fwd_dvalid   = in_req & own_dvalid & ~data_done_q;
  assign grant_ready  = in_req & mem_req_ready & ~req_done_q;
  assign grant_dready = in_req & mem_req_data_ready & own_rw & ~data_done_q;
  assign req_fire     = fwd_valid & mem_req_ready;
  assign data_fire    = fwd_dvalid & grant_dready;

  // Memory-side forwarding
  assign mem_req_valid      = fwd_valid;
  assign mem_req_addr       = in_req ? own_addr  : '0;
  assign mem_req_rw         = in_req & own_rw;
  assign mem_req_data_valid = fwd_dvalid;
  assign mem_req_data_bits  = in_req ? own_dbits : '0;
  assign mem_req_data_mask  = in_req ? own_dmask : '0;

  // Cache-side readys go only to the owner
  assign ic_mem_req_ready      = grant_ready  & ~owner_q;
  assign dc_mem_req_ready      = grant_ready  &  owner_q;
  assign ic_mem_req_data_ready = grant_dready & ~owner_q;
  assign dc_mem_req_data_ready = grant_dready &  owner_q;

  // Responses: valid routed to the owner, data broadcast to both
  assign ic_mem_resp_valid = in_resp & mem_resp_valid & ~owner_q;
  assign dc_mem_resp_valid = in_resp & mem_resp_valid &  owner_q;
  assign ic_mem_resp_data  = reset ? '0 : mem_resp_data;
  assign dc_mem_resp_data  = reset ? '0 : mem_resp_data;

  assign err_unexpected_resp = err_q & ~reset;

  // Next-state logic
  logic rd_all, dd_all;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    req_done_d   = req_done_q;
    data_done_d  = data_done_q;
    rd_all       = req_done_q  | req_fire;
    dd_all       = data_done_q | data_fire;

    // Any response not inside RESP is dropped and latched as an error
    err_d = err_q | (mem_resp_valid & (state_q != RESP));

    unique case (state_q)
      IDLE: begin
        req_done_d  = 1'b0;
        data_done_d = 1'b0;
        if (ic_mem_req_valid | dc_mem_req_valid) begin
          // On a tie, favour whoever did not complete the last transaction
          owner_d = (ic_mem_req_valid & dc_mem_req_valid) ? ~last_owner_q
                                                          : dc_mem_req_valid;
          state_d = REQ;
        end
      end

      REQ: begin
        if (~req_done_q & ~own_valid) begin
          // Requester withdrew before its request was accepted: abandon
          // without counting it as a turn, so last_owner stays put.
          state_d     = IDLE;
          req_done_d  = 1'b0;
          data_done_d = 1'b0;
        end else if (~own_rw) begin
          if (req_fire) begin
            state_d     = RESP;
            req_done_d  = 1'b0;
            data_done_d = 1'b0;
          end
        end else begin
          // Write completes once both channels have fired, in any order
          if (rd_all & dd_all) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            req_done_d   = 1'b0;
            data_done_d  = 1'b0;
          end else begin
            req_done_d  = rd_all;
            data_done_d = dd_all;
          end
        end
      end

      RESP: begin
        if (mem_resp_valid) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end

      default: begin
        state_d     = IDLE;
        req_done_d  = 1'b0;
        data_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      req_done_q   <= 1'b0;
      data_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      req_done_q   <= req_done_d;
      data_done_q  <= data_done_d;
      err_q        <= err_d;
    end
  end

endmodule
